// File: rtl/mix_columns_seq.sv
// mix_columns_seq
//   Applies AES MixColumns to a 32*NB-bit state through one shared 32-bit
//   combinational MixColumns datapath, one column per clock. The state is
//   transformed in place by rotation: each RUN cycle the top column is mixed
//   and re-enters at the bottom, so after NB cycles the column order is back
//   where it started.
//
//   Optional feature (macro INV_MIXCOL_EN): adds input 'inv', sampled at
//   acceptance. inv = 1 yields InvMixColumns as MixColumns applied three
//   times (three full rotations, 3*NB cycles). Without the macro there is no
//   inv port and only the forward transform exists.
//
//   Handshake: a transfer happens on a rising clk edge where valid and ready
//   are both high. A producer keeps valid and data steady until that edge.
//   The block holds out_valid and out_data steady until out_ready is seen.
//
// Ports
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   inv         (INV_MIXCOL_EN only) 1 = inverse transform for this state
//   in_valid    in_data is valid
//   in_ready    block can accept a state (in DONE this follows out_ready)
//   in_data     state; column 0 in the MSBs, byte 0 of a column in its MSBs
//   out_valid   out_data holds a finished state
//   out_ready   consumer accepts out_data
//   out_data    transformed state, same layout as in_data
//   busy        high while in RUN
//   dbg_state   current FSM state (IDLE=0, RUN=1, DONE=2)
module mix_columns_seq #(
    parameter int NB = 4
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef INV_MIXCOL_EN
    input  logic              inv,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [32*NB-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NB-1:0]  out_data,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int W  = 32 * NB;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(NB - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] col_cnt;
    logic [W-1:0]  sreg;
    logic [31:0]   mix_out;
    logic          accept;
    logic          last_pass;

    // Multiply by x (0x02) in GF(2^8), reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column: circulant matrix rows {2,3,1,1}; 3*a = xtime(a) ^ a.
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {r0, r1, r2, r3};
    endfunction

    assign mix_out = mix_col(sreg[W-1 -: 32]);

`ifdef INV_MIXCOL_EN
    logic       inv_r;
    logic [1:0] pass_cnt;

    // The inverse needs three full rotations; the forward form needs one.
    assign last_pass = !inv_r || (pass_cnt == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_r    <= 1'b0;
            pass_cnt <= 2'd0;
        end else if (accept) begin
            inv_r    <= inv;
            pass_cnt <= 2'd0;
        end else if (state == RUN && col_cnt == COL_LAST && !last_pass) begin
            pass_cnt <= pass_cnt + 2'd1;
        end
    end
`else
    assign last_pass = 1'b1;
`endif

    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            // Accepting while the result leaves lets back-to-back states
            // flow without a bubble cycle.
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
    assign out_data  = sreg;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            col_cnt <= '0;
            sreg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sreg    <= in_data;
                        col_cnt <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sreg <= {sreg[W-33:0], mix_out};
                    if (col_cnt == COL_LAST) begin
                        col_cnt <= '0;
                        if (last_pass) state <= DONE;
                    end else begin
                        col_cnt <= col_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            sreg    <= in_data;
                            col_cnt <= '0;
                            state   <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
module tb_mix_columns_seq;

    localparam int NB = 4;
    localparam int W  = 32 * NB;

    localparam logic [W-1:0] VEC1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [W-1:0] VEC1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [W-1:0] VEC2_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [W-1:0] VEC2_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         busy;
    logic [1:0]   dbg_state;
`ifdef INV_MIXCOL_EN
    logic         inv = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [W-1:0] exp_q[$];
    int           acc_q[$];
    int           lat_q[$];

    mix_columns_seq #(.NB(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef INV_MIXCOL_EN
        .inv       (inv),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    // Matrix product with the forward {2,3,1,1} or inverse {14,11,13,9}
    // circulant coefficients.
    function automatic logic [31:0] col_model(input logic [31:0] c, input bit inverse);
        logic [7:0] a[4];
        logic [7:0] k[4];
        logic [7:0] r;
        logic [31:0] res;
        if (inverse) k = '{8'd14, 8'd11, 8'd13, 8'd9};
        else         k = '{8'd2, 8'd3, 8'd1, 8'd1};
        for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
        res = '0;
        for (int i = 0; i < 4; i++) begin
            r = 8'h00;
            for (int j = 0; j < 4; j++) r = r ^ gmul(k[(j - i + 4) % 4], a[j]);
            res[31-8*i -: 8] = r;
        end
        return res;
    endfunction

    function automatic logic [W-1:0] state_model(input logic [W-1:0] s, input bit inverse);
        logic [W-1:0] res;
        res = '0;
        for (int c = 0; c < NB; c++)
            res[W-1-32*c -: 32] = col_model(s[W-1-32*c -: 32], inverse);
        return res;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit cur_inv();
`ifdef INV_MIXCOL_EN
        return inv;
`else
        return 1'b0;
`endif
    endfunction

    // Scoreboard: one pending state at most; the result is due a fixed
    // number of cycles after acceptance and must stay put until taken.
    always @(negedge clk) begin
        bit exp_valid;
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            lat_q.delete();
        end else begin
            exp_valid = (exp_q.size() > 0) && (cyc - acc_q[0] >= lat_q[0]);
            chk("out_valid", W'(out_valid), W'(exp_valid));
            chk("busy", W'(busy), W'((exp_q.size() > 0) && !exp_valid));
            chk("in_ready", W'(in_ready), W'((exp_q.size() == 0) || (exp_valid && out_ready)));
            if (exp_valid && out_valid) begin
                chk("out_data", out_data, exp_q[0]);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                    void'(lat_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(state_model(in_data, cur_inv()));
                acc_q.push_back(cyc + 1);
                lat_q.push_back(cur_inv() ? 3 * NB : NB);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [W-1:0] d, input bit iv);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
`ifdef INV_MIXCOL_EN
        inv = iv;
`else
        if (iv) $display("note: inverse request ignored in forward-only build");
`endif
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) chk("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string nm, input logic [W-1:0] exp);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk({nm, "_timeout"}, 1, 0);
        else       chk(nm, out_data, exp);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_in_ready"},  W'(in_ready),  W'(1));
        chk({nm, "_out_valid"}, W'(out_valid), W'(0));
        chk({nm, "_busy"},      W'(busy),      W'(0));
        chk({nm, "_out_data"},  out_data,      '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int sent;
        bit acc;

        // Model pinned to known FIPS-197 column results.
        chk("model_vec1", state_model(VEC1_IN, 1'b0), VEC1_OUT);
        chk("model_vec2", state_model(VEC2_IN, 1'b0), VEC2_OUT);
        chk("model_inv",  state_model(VEC1_OUT, 1'b1), VEC1_IN);

        // 1. reset, no traffic
        #12;
        check_reset_outputs("reset_low");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_idle");

        // 2. FIPS vector, consumer always ready
        out_ready = 1'b1;
        send(VEC1_IN, 1'b0);
        wait_out("fips_vec", VEC1_OUT);
        @(posedge clk);
        #1;

        // 3. back-to-back with a stalled consumer
        out_ready = 1'b0;
        send(VEC1_IN, 1'b0);
        in_valid = 1'b1;
        in_data  = VEC2_IN;
        wait_out("stall_first", VEC1_OUT);
        repeat (5) @(negedge clk);
        chk("stall_held", out_data, VEC1_OUT);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_in_ready", W'(in_ready), W'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("b2b_busy", W'(busy), W'(1));
        wait_out("b2b_second", VEC2_OUT);
        @(posedge clk);
        #1;

        // 4. reset in the middle of RUN
        send(VEC1_IN, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("no_valid_after_reset", W'(out_valid), W'(0));
        @(posedge clk);
        #1;
        send(VEC1_IN, 1'b0);
        wait_out("after_reset", VEC1_OUT);
        @(posedge clk);
        #1;

        // 5. in_valid toggling with other data during RUN
        send(VEC2_IN, 1'b0);
        for (int i = 0; i < NB - 2; i++) begin
            in_valid = ~in_valid;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_out("ignore_run_input", VEC2_OUT);
        @(posedge clk);
        #1;

`ifdef INV_MIXCOL_EN
        // 6. inverse transform
        send(VEC1_OUT, 1'b1);
        inv = 1'b0;
        wait_out("inv_vec", VEC1_IN);
        @(posedge clk);
        #1;
`endif

        // Random traffic with a randomly stalling consumer.
        sent = 0;
        for (int c = 0; c < 2000 && sent < 24; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                in_valid = 1'b0;
                sent++;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < 24 && $urandom_range(0, 2) != 0) begin
                in_valid = 1'b1;
                in_data  = {$urandom, $urandom, $urandom, $urandom};
`ifdef INV_MIXCOL_EN
                inv = 1'($urandom_range(0, 1));
`endif
            end
        end
        chk("random_all_sent", W'(sent), W'(24));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
        chk("drain_empty", W'(exp_q.size()), W'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
